// File: rtl/c17_pkg.sv
// Shared lane geometry and the tail of the c17 function, so the split after
// stage 1 finishes exactly like the unsplit lane.
package c17_pkg;

    localparam int LANE_IN_W  = 5;
    localparam int LANE_OUT_W = 2;

    localparam int N1_IDX  = 0;
    localparam int N2_IDX  = 1;
    localparam int N3_IDX  = 2;
    localparam int N6_IDX  = 3;
    localparam int N7_IDX  = 4;

    localparam int N22_IDX = 0;
    localparam int N23_IDX = 1;

    typedef logic [LANE_IN_W-1:0]  lane_in_t;
    typedef logic [LANE_OUT_W-1:0] lane_out_t;

    // mode=1 folds N22 into N23.
    function automatic lane_out_t c17_finish(
        input logic mode,
        input logic n10,
        input logic n16,
        input logic n19
    );
        lane_out_t r;
        r[N22_IDX] = ~(n10 & n16);
        r[N23_IDX] = ~(n16 & n19) ^ (mode & r[N22_IDX]);
        return r;
    endfunction

endpackage

// File: rtl/c17_lane.sv
// One combinational c17 lane; also exposes N10/N16/N19 so the top can cut the
// cone in half when it is pipelined.
module c17_lane
    import c17_pkg::*;
(
    input  logic                  mode,
    input  logic [LANE_IN_W-1:0]  lane_in,
    output logic [LANE_OUT_W-1:0] lane_out,
    output logic                  n10,
    output logic                  n16,
    output logic                  n19
);

    logic n11;

    assign n10      = ~(lane_in[N1_IDX] & lane_in[N3_IDX]);
    assign n11      = ~(lane_in[N3_IDX] & lane_in[N6_IDX]);
    assign n16      = ~(lane_in[N2_IDX] & n11);
    assign n19      = ~(n11 & lane_in[N7_IDX]);
    assign lane_out = c17_finish(mode, n10, n16, n19);

endmodule

// File: rtl/c17_pipe_misr.sv
// LANES c17 lanes behind a 1- or 2-deep elastic pipeline with a global stall,
// plus a MISR signature and saturating count of every delivered result.
module c17_pipe_misr
    import c17_pkg::*;
#(
    parameter int               LANES     = 4,
    parameter int               PIPE      = 2,
    parameter int               MISR_W    = 2*LANES,
    parameter logic [MISR_W-1:0] MISR_POLY = 'h3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5*LANES-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*LANES-1:0]  out_data,
    input  logic                sig_clear,
    output logic [MISR_W-1:0]   sig_out,
    output logic [15:0]         count
);

    logic                  advance;
    logic                  fire;
    logic [LANES-1:0]      tap_n10, tap_n16, tap_n19;
    logic [2*LANES-1:0]    comb_out;
    logic [2*LANES-1:0]    stage_data;
    logic                  stage_valid;
    logic                  out_valid_reg;
    logic [2*LANES-1:0]    out_data_reg;
    logic [MISR_W-1:0]     sig_reg, sig_next, sig_base;
    logic [15:0]           count_reg, count_next, count_base;

    assign advance  = ~out_valid_reg | out_ready;
    assign fire     = out_valid_reg & out_ready;
    assign in_ready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            c17_lane u_lane (
                .mode     (mode),
                .lane_in  (in_data[gi*LANE_IN_W +: LANE_IN_W]),
                .lane_out (comb_out[gi*LANE_OUT_W +: LANE_OUT_W]),
                .n10      (tap_n10[gi]),
                .n16      (tap_n16[gi]),
                .n19      (tap_n19[gi])
            );
        end

        if (MISR_W != 2*LANES) begin : g_bad_misr_w
            $error("c17_pipe_misr: MISR_W must equal 2*LANES");
        end

        if (PIPE == 2) begin : g_pipe2
            logic             s1_valid_reg;
            logic             s1_mode_reg;
            logic [LANES-1:0] s1_n10_reg, s1_n16_reg, s1_n19_reg;
            logic             unused_comb;

            // Mode travels with its vector so a later mode change cannot touch it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_reg <= 1'b0;
                    s1_mode_reg  <= 1'b0;
                    s1_n10_reg   <= '0;
                    s1_n16_reg   <= '0;
                    s1_n19_reg   <= '0;
                end else if (advance) begin
                    s1_valid_reg <= in_valid;
                    s1_mode_reg  <= mode;
                    s1_n10_reg   <= tap_n10;
                    s1_n16_reg   <= tap_n16;
                    s1_n19_reg   <= tap_n19;
                end
            end

            for (gi = 0; gi < LANES; gi++) begin : g_fin
                assign stage_data[gi*LANE_OUT_W +: LANE_OUT_W] =
                    c17_finish(s1_mode_reg, s1_n10_reg[gi], s1_n16_reg[gi], s1_n19_reg[gi]);
            end

            assign stage_valid = s1_valid_reg;
            assign unused_comb = ^comb_out;
        end else if (PIPE == 1) begin : g_pipe1
            logic unused_taps;
            assign stage_data  = comb_out;
            assign stage_valid = in_valid;
            assign unused_taps = ^{tap_n10, tap_n16, tap_n19};
        end else begin : g_bad_pipe
            $error("c17_pipe_misr: PIPE must be 1 or 2");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (advance) begin
            out_valid_reg <= stage_valid;
            out_data_reg  <= stage_data;
        end
    end

    // Clear is applied before the fire is absorbed.
    always_comb begin
        sig_base   = sig_clear ? '0 : sig_reg;
        count_base = sig_clear ? '0 : count_reg;
        sig_next   = sig_base;
        count_next = count_base;
        if (fire) begin
            sig_next = {sig_base[MISR_W-2:0], 1'b0}
                     ^ (sig_base[MISR_W-1] ? MISR_POLY : '0)
                     ^ out_data_reg;
            if (count_base != 16'hFFFF) begin
                count_next = count_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_reg   <= '0;
            count_reg <= '0;
        end else begin
            sig_reg   <= sig_next;
            count_reg <= count_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign sig_out   = sig_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_c17_pipe_misr.sv
// Directed checks on a 1-lane 2-deep instance and a randomised scoreboard run
// on a 4-lane 1-deep instance.
module tb_c17_pipe_misr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sig_clear;
    logic [4:0]  a_in_data;
    logic [1:0]  a_out_data, a_sig;
    logic [15:0] a_count;

    logic        b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sig_clear;
    logic [19:0] b_in_data;
    logic [7:0]  b_out_data, b_sig;
    logic [15:0] b_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_sig;
    logic [7:0] exp_v;
    int         sent, got, cyc;

    c17_pipe_misr #(.LANES(1), .PIPE(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (a_mode),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .sig_clear (a_sig_clear),
        .sig_out   (a_sig),
        .count     (a_count)
    );

    c17_pipe_misr #(.LANES(4), .PIPE(1)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (b_mode),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .sig_clear (b_sig_clear),
        .sig_out   (b_sig),
        .count     (b_count)
    );

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_val);
        n_checks++;
        if (got_v === exp_val) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_val);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] c17_ref(input logic md, input logic [4:0] v);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
        {n7, n6, n3, n2, n1} = v;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        n22 = ~(n10 & n16);
        n23 = ~(n16 & n19);
        if (md) n23 = n23 ^ n22;
        return {n23, n22};
    endfunction

    initial begin
        rst_n = 1'b0;
        a_mode = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1; a_sig_clear = 0;
        b_mode = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1; b_sig_clear = 0;
        #3;
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_sig",   a_sig,       0);
        check("rst_a_count", a_count,     0);
        check("rst_b_valid", b_out_valid, 0);
        #9 rst_n = 1'b1;
        tick;

        // mode 0: 00 -> 00, 1F -> 01, two edges after presentation
        a_mode = 0; a_in_valid = 1; a_in_data = 5'h00; tick;
        check("m0_latency", a_out_valid, 0);
        a_in_data = 5'h1F; tick;
        check("m0_v0_valid", a_out_valid, 1);
        check("m0_v0", a_out_data, 2'b00);
        a_in_valid = 0; tick;
        check("m0_v1", a_out_data, 2'b01);
        tick;
        check("m0_drain", a_out_valid, 0);

        // mode 1: 00 -> 00, 1F -> 11 with mode dropped while in flight
        a_mode = 1; a_in_valid = 1; a_in_data = 5'h00; tick;
        a_in_data = 5'h1F; tick;
        check("m1_v0", a_out_data, 2'b00);
        a_in_valid = 0; a_mode = 0; tick;
        check("m1_toggle", a_out_data, 2'b11);
        tick;
        check("count_four", a_count, 4);

        a_sig_clear = 1; tick; a_sig_clear = 0;
        check("clr_sig",   a_sig,   0);
        check("clr_count", a_count, 0);

        // stall with two vectors queued: A=1F/mode1 -> 11, B=1F/mode0 -> 01
        a_out_ready = 0; a_mode = 1; a_in_data = 5'h1F; a_in_valid = 1; tick;
        a_mode = 0; tick;
        a_in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready",  a_in_ready,  0);
            check("stall_valid",     a_out_valid, 1);
            check("stall_hold",      a_out_data,  2'b11);
            tick;
        end
        a_out_ready = 1; #1;
        check("stall_release", a_in_ready, 1);
        tick;
        check("stall_second_valid", a_out_valid, 1);
        check("stall_second", a_out_data, 2'b01);
        tick;
        check("stall_empty", a_out_valid, 0);
        check("stall_count", a_count, 2);

        a_sig_clear = 1; tick; a_sig_clear = 0;

        // MISR: three fires of 01 -> 01, 11, 00
        a_mode = 0; a_in_data = 5'h1F; a_in_valid = 1;
        tick; tick; tick;
        a_in_valid = 0;
        check("misr_1", a_sig, 2'b01);
        tick;
        check("misr_2", a_sig, 2'b11);
        tick;
        check("misr_3", a_sig, 2'b00);
        check("misr_count", a_count, 3);

        // clear together with a fire of 10 (in_data 10 = only N7 set)
        a_in_data = 5'h10; a_in_valid = 1; tick;
        a_in_valid = 0; tick;
        check("v10_data", a_out_data, 2'b10);
        a_sig_clear = 1; tick; a_sig_clear = 0;
        check("clrfire_sig",   a_sig,   2'b10);
        check("clrfire_count", a_count, 1);

        // async reset with a full pipe
        a_out_ready = 0; a_mode = 1; a_in_data = 5'h00; a_in_valid = 1; tick;
        a_in_data = 5'h1F; tick;
        a_in_valid = 0;
        check("full_valid", a_out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_valid", a_out_valid, 0);
        check("async_sig",   a_sig,       0);
        check("async_count", a_count,     0);
        #3 rst_n = 1'b1;
        a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("no_stale", a_out_valid, 0);
        end

        // random run on 4 lanes, PIPE=1
        m_sig = '0; sent = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            b_mode      = 1'($urandom_range(0, 1));
            b_in_data   = 20'($urandom);
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", b_out_data, 32'hDEAD);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_out", b_out_data, exp_v);
                end
                m_sig = {m_sig[6:0], 1'b0} ^ (m_sig[7] ? 8'h03 : 8'h00) ^ b_out_data;
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                for (int l = 0; l < 4; l++) begin
                    exp_v[2*l +: 2] = c17_ref(b_mode, b_in_data[5*l +: 5]);
                end
                exp_q.push_back(exp_v);
                sent++;
            end
            tick;
            cyc++;
        end
        b_in_valid = 0;
        check("rand_delivered", got,     1000);
        check("rand_count",     b_count, 1000);
        check("rand_sig",       b_sig,   m_sig);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
